ram1_ctrl: RTL and testbench
============================

# ram1_ctrl

Initiator-side controller for the RAM1 data memory port. Accepts single-word load/store requests from the MEM stage and stalls the pipeline while the transaction runs. Sequences chip-enable, read and write strobes on the RAM1 interface (the port served by the RAM1 model or the board SRAM). Returns the read word with a one-cycle ack.

## Interface

**Parameters**
- WAIT_CYCLES, default 2: cycles the read strobe or write pulse is held; legal range ≥ 1.

**Ports** (clock and reset first)
- clk, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- cpu_req, in, 1: request valid; held until stall drops.
- cpu_we, in, 1: 1 = write, 0 = read.
- cpu_addr, in, `DataAddrBus: byte address; bits [1:0] ignored.
- cpu_wdata, in, `DataBus: store data.
- cpu_rdata, out, `DataBus: registered load data.
- cpu_ack, out, 1: one-cycle completion pulse.
- cpu_stall, out, 1: pipeline stall.
- mem_ce, out, 1: RAM chip enable (`RamChipEnable` = 1).
- mem_re, out, 1: read enable (`RamReadEnable` = 1).
- mem_we, out, 1: write enable (`RamWriteEnable` = 1).
- mem_addr, out, `DataAddrBus: word address, equal to {2'b00, addr[31:2]}.
- mem_data_o, out, `DataBus: write data toward the RAM.
- mem_data_i, in, `DataBus: read data from the RAM (combinational in the model).

## Operation

**Request latching**
- In IDLE, cpu_req=1 latches cpu_we, cpu_addr and cpu_wdata into registers.
- Input changes after acceptance are ignored until the transaction completes.

**States**
- IDLE: all strobes 0, mem_addr 0, mem_data_o 0.
  - cpu_req & !cpu_we → RD.
  - cpu_req & cpu_we → WR_SETUP.
- RD: ce=1, re=1, we=0, address driven. Stays for WAIT_CYCLES cycles. On the last edge: cpu_rdata ← mem_data_i, then → DONE.
- WR_SETUP (1 cycle): ce=1, re=0, we=0; address and data driven. Then → WR_PULSE.
- WR_PULSE: ce=1, we=1 for WAIT_CYCLES cycles. Then → WR_HOLD.
- WR_HOLD (1 cycle): ce=1, we=0; address and data still driven. Then → DONE.
- DONE (1 cycle): cpu_ack=1, strobes 0, cpu_req ignored. Then → IDLE.

**Stall**
- cpu_stall = (state ∉ {IDLE, DONE}) | (state == IDLE & cpu_req). Combinational.
- The stall drops in DONE, so the pipeline advances on that edge and the controller does not re-capture the same request.

**Outputs**
- cpu_rdata holds its value until the next read completes; writes do not modify it.
- mem_re and mem_we are never high together.
- mem_ce is high in every non-IDLE, non-DONE state.

**Counter**
- Wait counter width is $clog2(WAIT_CYCLES+1).
- Loaded with WAIT_CYCLES-1 on entry to RD or WR_PULSE; the state exits when the counter reaches 0.

## Timing

- Cycle 0 is the first cycle cpu_req is high in IDLE.
- Read: RD for cycles 1..WAIT_CYCLES; ack and new rdata in cycle WAIT_CYCLES+1.
- Write: setup in cycle 1; we high for cycles 2..WAIT_CYCLES+1; hold in cycle WAIT_CYCLES+2; ack in cycle WAIT_CYCLES+3.
- Back-to-back: if cpu_req is high in the IDLE cycle after DONE, the next transaction starts there. Minimum issue interval is WAIT_CYCLES+2 cycles for reads and WAIT_CYCLES+4 for writes.

**Reset values** (rst=1, effective immediately, including mid-transaction)
- State = IDLE; counter and latched registers = 0.
- Zero outputs: cpu_rdata, cpu_ack, mem_ce, mem_re, mem_we, mem_addr, mem_data_o.
- cpu_stall follows cpu_req.
- An aborted transaction never acks. A write aborted during WR_PULSE may leave the target word undefined.

**Address**
- Addresses wrap naturally; no range check.
- The RAM model decodes mem_addr[11:0] only.

## Structure

- Shared constants go in defines.v: `RamChipEnable`/`RamChipDisable`, `RamReadEnable`, `RamWriteEnable`, `DataBus`, `DataAddrBus`, `ZeroWord`, and the six state encodings (3-bit, `Ram1St*`).
- Single module; no sub-module is warranted. The FSM and counter are one registered process with async reset; strobe and stall decode is combinational.

## Test plan

All scenarios use WAIT_CYCLES=2 except the last, and pair the controller with the RAM1 model.

- Idle: cpu_req=0 for 10 cycles → ce=re=we=0, stall=0, ack=0, mem_data_o=0.
- Read: model word 0x010 = 0x12345678; read request at cpu_addr 0x40.
  - mem_addr=0x10 with re=1 in cycles 1–2.
  - ack=1 and cpu_rdata=0x12345678 in cycle 3.
  - stall=1 in cycles 0–2, stall=0 in cycle 3.
- Write then read: write 0xDEADBEEF to 0x44.
  - Setup in cycle 1, we=1 in cycles 2–3, hold in cycle 4, ack in cycle 5.
  - A following read of 0x44 returns 0xDEADBEEF.
  - cpu_rdata is unchanged during the write.
- Back-to-back: hold cpu_req through ack with different addr/data → second transaction starts in the cycle after DONE; first ack is exactly one cycle wide.
- Reset mid-write: assert rst in the second WR_PULSE cycle → mem_we and mem_ce fall in the same cycle, no ack, state IDLE after release.
- WAIT_CYCLES=1 read: ack in cycle 2; re high for exactly one cycle.

Source files
------------

// File: rtl/ram1_ctrl_pkg.sv
// ram1_ctrl_pkg: shared RAM1 port constants, bus widths and controller state encoding
package ram1_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam logic RAM_CHIP_ENABLE = 1'b1;
    localparam logic RAM_CHIP_DISABLE = 1'b0;
    localparam logic RAM_READ_ENABLE = 1'b1;
    localparam logic RAM_WRITE_ENABLE = 1'b1;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;
endpackage

// File: rtl/ram1_ctrl.sv
// ram1_ctrl: single-word load/store sequencer for the RAM1 port, stalling the pipeline per transaction
module ram1_ctrl import ram1_ctrl_pkg::*; #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    output logic              mem_ce,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    state_t              state, next;
    logic [CW-1:0]       cnt;
    logic [ADDR_W-3:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                busy, wr_phase;

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:     next = cpu_req ? (cpu_we ? ST_WR_SETUP : ST_RD) : ST_IDLE;
            ST_RD:       next = (cnt == '0) ? ST_DONE : ST_RD;
            ST_WR_SETUP: next = ST_WR_PULSE;
            ST_WR_PULSE: next = (cnt == '0) ? ST_WR_HOLD : ST_WR_PULSE;
            ST_WR_HOLD:  next = ST_DONE;
            default:     next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rdata <= ZERO_WORD;
        end else begin
            state <= next;
            if (state == ST_IDLE && cpu_req) begin
                addr_q  <= cpu_addr[ADDR_W-1:2];
                wdata_q <= cpu_wdata;
            end
            // Counter reloads on entry to either timed state and exits on zero
            if ((next == ST_RD && state != ST_RD) || (next == ST_WR_PULSE && state != ST_WR_PULSE))
                cnt <= CW'(WAIT_CYCLES - 1);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == ST_RD && cnt == '0)
                cpu_rdata <= mem_data_i;
        end
    end

    always_comb begin
        busy       = state inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
        wr_phase   = state inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
        mem_ce     = busy ? RAM_CHIP_ENABLE : RAM_CHIP_DISABLE;
        mem_re     = (state == ST_RD) ? RAM_READ_ENABLE : ~RAM_READ_ENABLE;
        mem_we     = (state == ST_WR_PULSE) ? RAM_WRITE_ENABLE : ~RAM_WRITE_ENABLE;
        mem_addr   = busy ? {2'b00, addr_q} : '0;
        mem_data_o = wr_phase ? wdata_q : ZERO_WORD;
        cpu_ack    = state == ST_DONE;
        cpu_stall  = busy || (state == ST_IDLE && cpu_req);
    end
endmodule

// File: tb/tb_ram1_ctrl.sv
// tb_ram1_ctrl: scoreboard bench for ram1_ctrl with RAM1 memory models and a word-array reference model
module tb_ram1_ctrl;
    localparam int W = 2;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 0, rst = 1;
    logic        cpu_req = 0, cpu_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
    logic        cpu_ack, cpu_stall, mem_ce, mem_re, mem_we;
    logic [31:0] mem_addr, mem_data_o, mem_data_i;

    logic        r1_req = 0, r1_we = 0;
    logic [31:0] r1_addr = 0, r1_wdata = 0, r1_rdata;
    logic        r1_ack, r1_stall, r1_ce, r1_re, r1_wen;
    logic [31:0] r1_maddr, r1_mdo, r1_mdi;

    logic [31:0] ram0 [4096];
    logic [31:0] ram1 [4096];
    logic [31:0] ref_mem [4096];
    logic [31:0] last_rd = 0;
    exp_t        exp_q [$];
    int          cyc = 0, checks = 0, errors = 0;

    ram1_ctrl #(.WAIT_CYCLES(W)) u0 (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    ram1_ctrl #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .cpu_req(r1_req), .cpu_we(r1_we), .cpu_addr(r1_addr),
        .cpu_wdata(r1_wdata), .cpu_rdata(r1_rdata), .cpu_ack(r1_ack), .cpu_stall(r1_stall),
        .mem_ce(r1_ce), .mem_re(r1_re), .mem_we(r1_wen), .mem_addr(r1_maddr),
        .mem_data_o(r1_mdo), .mem_data_i(r1_mdi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM1 models: combinational read, write on the clock edge while ce & we
    assign mem_data_i = ram0[mem_addr[11:0]];
    assign r1_mdi     = ram1[r1_maddr[11:0]];
    always @(posedge clk) begin
        if (mem_ce && mem_we) ram0[mem_addr[11:0]] <= mem_data_o;
        if (r1_ce && r1_wen) ram1[r1_maddr[11:0]] <= r1_mdo;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cpu_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got ack=1 expected ack=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_rdata", cpu_rdata, e.rdata);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
        if (!rst) chk("re_we_exclusive", {31'b0, mem_re & mem_we}, 0);
    end

    // One transaction from its IDLE cycle (k=0) through DONE (k=lat), checking strobes per cycle
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int lat, c0;
        logic [11:0] idx;
        @(posedge clk);
        #1;
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        c0  = cyc;
        lat = we ? W + 3 : W + 1;
        idx = addr[13:2];
        if (we) ref_mem[idx] = wd;
        else last_rd = ref_mem[idx];
        exp_q.push_back('{last_rd, c0 + lat});
        for (int k = 0; k <= lat; k++) begin
            logic ce_e;
            @(negedge clk);
            ce_e = k >= 1 && k < lat;
            chk("stall", {31'b0, cpu_stall}, {31'b0, k < lat});
            chk("ce", {31'b0, mem_ce}, {31'b0, ce_e});
            chk("re", {31'b0, mem_re}, {31'b0, !we && k >= 1 && k <= W});
            chk("we", {31'b0, mem_we}, {31'b0, we && k >= 2 && k <= W + 1});
            if (ce_e) chk("mem_addr", mem_addr, {2'b00, addr[31:2]});
            if (we && ce_e) chk("mem_data_o", mem_data_o, wd);
            if (we) chk("rdata_hold", cpu_rdata, last_rd);
            if (k == 1) begin
                cpu_we = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom;
            end
        end
    endtask

    task automatic gap(input int n);
        @(posedge clk);
        #1;
        cpu_req = 0;
        cpu_addr = $urandom;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram0[i] = v;
            ref_mem[i] = v;
            ram1[i] = '0;
        end
        ram0[12'h010] = 32'h12345678;
        ref_mem[12'h010] = 32'h12345678;
        ram1[5] = 32'hCAFEF00D;

        #1;
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ack", {31'b0, cpu_ack}, 0);
        chk("rst_strobes", {29'b0, mem_ce, mem_re, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall_lo", {31'b0, cpu_stall}, 0);
        cpu_req = 1;
        #1;
        chk("rst_stall_follows", {31'b0, cpu_stall}, 1);
        cpu_req = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_strobes", {29'b0, mem_ce, mem_re, mem_we}, 0);
            chk("idle_stall_ack", {30'b0, cpu_stall, cpu_ack}, 0);
            chk("idle_data_o", mem_data_o, 0);
        end

        txn(0, 32'h40, 0);
        gap(2);
        txn(1, 32'h44, 32'hDEADBEEF);
        gap(1);
        txn(0, 32'h44, 0);
        txn(1, 32'h48, 32'h0BADF00D);
        txn(0, 32'h48, 0);
        txn(0, 32'h40, 0);
        gap(3);

        // Abort a write in its second pulse cycle
        @(posedge clk);
        #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h800; cpu_wdata = 32'h55AA55AA;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_we", {31'b0, mem_we}, 1);
        rst = 1;
        last_rd = 0;
        #1;
        chk("abort_we", {31'b0, mem_we}, 0);
        chk("abort_ce", {31'b0, mem_ce}, 0);
        chk("abort_ack", {31'b0, cpu_ack}, 0);
        chk("abort_rdata", cpu_rdata, 0);
        cpu_req = 0;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_abort_idle", {29'b0, mem_ce, cpu_stall, cpu_ack}, 0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int g;
            a = {18'b0, 6'($urandom_range(0, 63)), 2'($urandom)};
            txn(1'($urandom), a, $urandom);
            g = $urandom_range(0, 2);
            if (g > 0) gap(g);
        end
        gap(3);
        chk("queue_empty", exp_q.size(), 0);

        @(posedge clk);
        #1;
        r1_req = 1; r1_we = 0; r1_addr = 32'h14;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk("w1_re", {31'b0, r1_re}, {31'b0, k == 1});
            chk("w1_ack", {31'b0, r1_ack}, {31'b0, k == 2});
            chk("w1_stall", {31'b0, r1_stall}, {31'b0, k < 2});
            if (k == 2) chk("w1_rdata", r1_rdata, 32'hCAFEF00D);
        end
        @(posedge clk);
        #1;
        r1_req = 0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
